// File: rtl/alu_sequencer_if.sv
// Operand/opcode entry and ALU hookup bundle for the ALU sequencer.
// The slave modport faces the sequencer. The master modport faces the switch panel and the ALU.
interface alu_sequencer_if;
    logic [15:0] data_in;
    logic        enter;
    logic        clear;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_op;
    logic [16:0] alu_result;
    logic        alu_error;
    logic [16:0] result;
    logic        error;
    logic [2:0]  state;
    logic        done;
    logic        busy;

    modport slave (
        input  data_in, enter, clear, alu_result, alu_error,
        output alu_a, alu_b, alu_op, result, error, state, done, busy
    );

    modport master (
        output data_in, enter, clear, alu_result, alu_error,
        input  alu_a, alu_b, alu_op, result, error, state, done, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Steps an external ALU through operand A, operand B and opcode entry on enter-button edges.
// It captures the ALU result one cycle after the opcode loads and holds it for display.
module alu_sequencer (
    input  logic           clk,
    input  logic           resetN,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    typedef struct packed {
        logic [16:0] result;
        logic        error;
    } rsp_t;

    // Plain vector so unused codes 5-7 stay representable and fall back to WAIT_A.
    logic [2:0]  state_q, state_d;
    logic        enter_q;
    logic        enter_edge;
    logic        ld_a, ld_b, ld_op, capture;
    logic [15:0] alu_a_q, alu_b_q, alu_op_q;
    rsp_t        rsp_q;
    logic        done_q;

    assign enter_edge = bus.enter & ~enter_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= WAIT_A;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= bus.enter;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        capture = 1'b0;
        if (bus.clear) begin
            state_d = WAIT_A;
        end else begin
            case (state_q)
                WAIT_A: if (enter_edge) begin
                    ld_a    = 1'b1;
                    state_d = WAIT_B;
                end
                WAIT_B: if (enter_edge) begin
                    ld_b    = 1'b1;
                    state_d = WAIT_OP;
                end
                WAIT_OP: if (enter_edge) begin
                    ld_op   = 1'b1;
                    state_d = EXEC;
                end
                EXEC: begin
                    capture = 1'b1;
                    state_d = SHOW;
                end
                SHOW: if (enter_edge) state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_q    <= '0;
            done_q   <= 1'b0;
        end else if (bus.clear) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (ld_a)    alu_a_q  <= bus.data_in;
            if (ld_b)    alu_b_q  <= bus.data_in;
            if (ld_op)   alu_op_q <= bus.data_in;
            if (capture) rsp_q    <= '{result: bus.alu_result, error: bus.alu_error};
            done_q <= capture;
        end
    end

    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;
    assign bus.alu_op = alu_op_q;
    assign bus.result = rsp_q.result;
    assign bus.error  = rsp_q.error;
    assign bus.state  = state_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != SHOW);
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed checks of the ALU sequencer: entry flow, held button, clear, async reset and illegal state.
module tb_alu_sequencer;
    logic clk;
    logic resetN;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] d);
        bus.data_in = d;
        bus.enter   = 1'b1;
        step();
        bus.enter   = 1'b0;
        step();
    endtask

    initial begin
        resetN         = 1'b0;
        bus.data_in    = '0;
        bus.enter      = 1'b0;
        bus.clear      = 1'b0;
        bus.alu_result = 17'd2;
        bus.alu_error  = 1'b0;

        // reset state
        repeat (2) step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_a",     32'(bus.alu_a), 0);
        chk("rst_result",32'(bus.result), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_busy",  32'(bus.busy), 1);
        resetN = 1'b1;
        step();
        chk("idle_state", 32'(bus.state), 0);

        // nominal flow 1, 1, 0 -> result 2
        press(16'd1);
        chk("nom_a", 32'(bus.alu_a), 1);
        chk("nom_s1", 32'(bus.state), 1);
        press(16'd1);
        chk("nom_b", 32'(bus.alu_b), 1);
        bus.data_in = 16'd0;
        bus.enter   = 1'b1;
        step();
        chk("nom_exec", 32'(bus.state), 3);
        chk("nom_done_early", 32'(bus.done), 0);
        chk("nom_busy_exec", 32'(bus.busy), 1);
        bus.enter = 1'b0;
        step();
        chk("nom_done", 32'(bus.done), 1);
        chk("nom_result", 32'(bus.result), 2);
        chk("nom_error", 32'(bus.error), 0);
        chk("nom_show", 32'(bus.state), 4);
        chk("nom_busy", 32'(bus.busy), 0);
        step();
        chk("nom_done_pulse", 32'(bus.done), 0);
        chk("nom_show_hold", 32'(bus.state), 4);
        chk("nom_op", 32'(bus.alu_op), 0);
        press(16'hBEEF);
        chk("show_to_a", 32'(bus.state), 0);
        chk("show_a_hold", 32'(bus.alu_a), 1);
        chk("show_res_hold", 32'(bus.result), 2);

        // held button advances exactly once
        bus.data_in = 16'h00FF;
        bus.enter   = 1'b1;
        repeat (10) step();
        chk("held_state", 32'(bus.state), 1);
        chk("held_a", 32'(bus.alu_a), 32'h00FF);
        chk("held_b", 32'(bus.alu_b), 1);
        bus.enter = 1'b0;
        step();

        // clear beats an enter edge in WAIT_OP
        press(16'd7);
        chk("clr_pre", 32'(bus.state), 2);
        bus.data_in = 16'd5;
        bus.enter   = 1'b1;
        bus.clear   = 1'b1;
        step();
        chk("clr_state", 32'(bus.state), 0);
        chk("clr_op", 32'(bus.alu_op), 0);
        chk("clr_a", 32'(bus.alu_a), 0);
        chk("clr_b", 32'(bus.alu_b), 0);
        chk("clr_result", 32'(bus.result), 0);
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        step();

        // wide result, held through SHOW
        bus.alu_result = 17'h1FFFF;
        bus.alu_error  = 1'b1;
        press(16'd3);
        press(16'd4);
        bus.data_in = 16'd9;
        bus.enter   = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
        chk("wide_result", 32'(bus.result), 32'h1FFFF);
        chk("wide_error", 32'(bus.error), 1);
        chk("wide_op", 32'(bus.alu_op), 9);
        bus.alu_result = 17'h00001;
        bus.alu_error  = 1'b0;
        step();
        chk("wide_hold", 32'(bus.result), 32'h1FFFF);
        press(16'd0);
        chk("wide_hold_a", 32'(bus.result), 32'h1FFFF);
        chk("wide_hold_e", 32'(bus.error), 1);

        // clear during EXEC: no capture, no done
        press(16'd1);
        press(16'd1);
        bus.data_in = 16'd2;
        bus.enter   = 1'b1;
        step();
        chk("cexec_pre", 32'(bus.state), 3);
        bus.enter = 1'b0;
        bus.clear = 1'b1;
        step();
        chk("cexec_state", 32'(bus.state), 0);
        chk("cexec_done", 32'(bus.done), 0);
        chk("cexec_result", 32'(bus.result), 0);
        chk("cexec_error", 32'(bus.error), 0);
        bus.clear = 1'b0;
        step();

        // async reset mid-EXEC
        bus.alu_result = 17'h01234;
        press(16'd1);
        press(16'd2);
        bus.data_in = 16'd3;
        bus.enter   = 1'b1;
        step();
        chk("arst_pre", 32'(bus.state), 3);
        bus.enter = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_a", 32'(bus.alu_a), 0);
        chk("arst_op", 32'(bus.alu_op), 0);
        chk("arst_busy", 32'(bus.busy), 1);
        step();
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_result", 32'(bus.result), 0);

        // enter already high when reset releases counts as an edge
        bus.data_in = 16'h0042;
        bus.enter   = 1'b1;
        #2;
        resetN = 1'b1;
        step();
        chk("rel_state", 32'(bus.state), 1);
        chk("rel_a", 32'(bus.alu_a), 32'h42);
        bus.enter = 1'b0;
        step();

        // illegal state code recovers to WAIT_A
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        chk("ill_forced", 32'(bus.state), 6);
        step();
        chk("ill_state", 32'(bus.state), 0);
        chk("ill_a_hold", 32'(bus.alu_a), 32'h42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed: operands 16 bits, opcode 16 bits, result 17 bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 resetN  input  1  reset, asynchronous assert, active-low.
REQ-004 data_in  input  16  operand/opcode value from switches.
REQ-005 enter  input  1  debounced level from the enter push-button.
REQ-006 clear  input  1  synchronous abort and restart, active-high.
REQ-007 alu_a, alu_b, alu_op  output  16 each  registered operands and opcode driven to the ALU.
REQ-008 alu_result  input  17  combinational ALU result.
REQ-009 alu_error  input  1  combinational ALU error/carry flag.
REQ-010 result  output  17  latched ALU result.
REQ-011 error  output  1  latched ALU error.
REQ-012 state  output  3  current FSM state code.
REQ-013 done  output  1  one-cycle pulse when result/error are captured.
REQ-014 busy  output  1  high in every state except SHOW.

Function
REQ-015 The enter rising edge SHALL be detected as enter=1 with enter_q=0, where enter_q is enter registered on clk; only edges advance the FSM.
REQ-016 FSM states and codes SHALL be: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4; codes 5-7 SHALL return to WAIT_A on the next clock.
REQ-017 In WAIT_A, an enter edge SHALL load data_in into alu_a and move to WAIT_B.
REQ-018 In WAIT_B, an enter edge SHALL load data_in into alu_b and move to WAIT_OP.
REQ-019 In WAIT_OP, an enter edge SHALL load data_in into alu_op and move to EXEC.
REQ-020 EXEC SHALL last exactly one cycle; at its closing clock edge, result<=alu_result, error<=alu_error, done=1 for that following cycle, and the state becomes SHOW.
REQ-021 Latency from the WAIT_OP enter-edge clock to the done pulse SHALL be 2 clocks.
REQ-022 In SHOW, an enter edge SHALL move to WAIT_A; result and error SHALL hold until the next EXEC capture or clear.
REQ-023 alu_a, alu_b and alu_op SHALL change only on their own load edge or on clear/reset; they SHALL otherwise hold, including in SHOW.
REQ-024 enter held high SHALL advance exactly one state; a new edge requires enter to return low first.
REQ-025 An enter edge in EXEC SHALL be ignored; EXEC always completes.
REQ-026 When clear=1, the next state SHALL be WAIT_A and alu_a, alu_b, alu_op, result and error SHALL be zeroed, regardless of state.
REQ-027 When clear=1 and an enter edge coincide, clear SHALL win and no operand is loaded.
REQ-028 When clear=1 in EXEC, no capture and no done pulse SHALL occur.
REQ-029 result SHALL be the full 17-bit alu_result with no truncation or sign extension.
REQ-030 done SHALL be high only in the single cycle after EXEC and SHALL be low at all other times.

Reset
REQ-031 While resetN=0, the outputs SHALL be: state=WAIT_A, alu_a=alu_b=alu_op=0, result=0, error=0, done=0, busy=1, and enter_q=0.
REQ-032 Reset asserted in any state, including EXEC, SHALL take effect immediately without waiting for clk and SHALL suppress any pending capture.
REQ-033 After resetN deasserts, if enter is already high, the first rising clock SHALL count it as an edge, because enter_q resets to 0.

Verification
REQ-034 Nominal flow: enter edges with data_in=1, 1, 0 and ALU returning 17'd2/error=0 -> alu_a=1, alu_b=1, alu_op=0; done pulses 2 clocks after the third edge; result=2, error=0; state=4, busy=0.
REQ-035 Held button: enter held high for 10 cycles in WAIT_A with data_in=16'h00FF -> only alu_a=16'h00FF is loaded and state=1.
REQ-036 Clear priority: clear=1 together with an enter edge in WAIT_OP with data_in=5 -> state=0, alu_op=0 and all registers 0.
REQ-037 Async reset in EXEC: resetN dropped mid-cycle while state=3 -> outputs reset before the next clk edge; no done pulse.
REQ-038 Wide result: ALU returning 17'h1FFFF with error=1 -> result=17'h1FFFF and error=1, both held through SHOW until an enter edge followed by the next capture.
REQ-039 Illegal state: state forced to 6 -> state=0 after one clock.
